// File: rtl/trigger_capture_pkg.sv
// Shared types and helpers for the trigger capture block.
// The glitch filter in trigger_sync_filter is enabled by defining TRIG_CAPTURE_GLITCH_FILTER_EN.
package trigger_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

    localparam int DEF_W           = 32;
    localparam int DEF_W_S         = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 4;

    // Increment that sticks at max instead of wrapping; callers size max to their counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
        return (value >= max) ? max : value + 64'd1;
    endfunction

endpackage

// File: rtl/trigger_sync_filter.sv
// Synchronises the external trigger, optionally glitch-filters it, and produces rise/fall strobes.
// Filter is present only when TRIG_CAPTURE_GLITCH_FILTER_EN is defined.
module trigger_sync_filter
    import trigger_capture_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger_in,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_params
        $error("trigger_sync_filter: SYNC_STAGES and FILT_LEN must both be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_s;
    logic                   trig_f;
    logic                   trig_d;

    // Reset to 1 so a line already high when reset releases does not look like a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_in};
        end
    end

    assign trig_s = sync_q[SYNC_STAGES-1];

`ifdef TRIG_CAPTURE_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN);

    logic [CW-1:0] filt_cnt;
    logic          filt_q;

    // filt_cnt counts how long trig_s has disagreed with the filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= 1'b1;
            filt_cnt <= '0;
        end else if (trig_s == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == CW'(FILT_LEN - 1)) begin
            filt_q   <= trig_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign trig_f = filt_q;
`else
    assign trig_f = trig_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d <= 1'b1;
        end else begin
            trig_d <= trig_f;
        end
    end

    assign rise = trig_f & ~trig_d;
    assign fall = ~trig_f & trig_d;

endmodule

// File: rtl/trigger_capture.sv
// Measures high/low durations of an external trigger and counts accepted rising edges.
// Optional glitch filter: define TRIG_CAPTURE_GLITCH_FILTER_EN.
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int W_s         = DEF_W_S,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           trigger_in,
    input  logic           meas_ready,
    output logic           meas_valid,
    output logic [W_s-1:0] meas_hi,
    output logic [W_s-1:0] meas_lo,
    output logic [W-1:0]   trigger_count,
    output logic           overrun,
    input  logic           clr_overrun
);

    localparam logic [63:0] CNT_MAX = 64'({W_s{1'b1}});

    cap_state_t     state;
    logic [W_s-1:0] hi_cnt;
    logic [W_s-1:0] lo_cnt;
    logic           rise;
    logic           fall;
    logic           emit;
    logic           transfer;

    trigger_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .trigger_in (trigger_in),
        .rise       (rise),
        .fall       (fall)
    );

    // Valid/ready: a beat moves when meas_valid & meas_ready at a clk edge; data holds until then.
    always_comb begin
        emit     = enable && (state == LOW) && rise;
        transfer = meas_valid && meas_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hi_cnt        <= '0;
            lo_cnt        <= '0;
            trigger_count <= '0;
            meas_valid    <= 1'b0;
            meas_hi       <= '0;
            meas_lo       <= '0;
            overrun       <= 1'b0;
        end else begin
            if (!enable) begin
                state  <= IDLE;
                hi_cnt <= '0;
                lo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state         <= HIGH;
                            hi_cnt        <= W_s'(1);
                            trigger_count <= trigger_count + W'(1);
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state  <= LOW;
                            lo_cnt <= W_s'(1);
                        end else begin
                            hi_cnt <= W_s'(sat_inc(64'(hi_cnt), CNT_MAX));
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state         <= HIGH;
                            hi_cnt        <= W_s'(1);
                            trigger_count <= trigger_count + W'(1);
                        end else begin
                            lo_cnt <= W_s'(sat_inc(64'(lo_cnt), CNT_MAX));
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // A full, stalled output register drops the new period and flags it.
            if (emit && (!meas_valid || meas_ready)) begin
                meas_valid <= 1'b1;
                meas_hi    <= hi_cnt;
                meas_lo    <= lo_cnt;
            end else if (transfer) begin
                meas_valid <= 1'b0;
            end

            if (emit && meas_valid && !meas_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed self-checking bench for trigger_capture, with a second instance at W_s=4 for saturation.
module tb_trigger_capture;

`ifdef TRIG_CAPTURE_GLITCH_FILTER_EN
    // Filtered build: every pulse and gap must be at least FILT_LEN (4) cycles wide.
    localparam int HI_A = 4, LO_A = 5, OV_H = 5, OV_L = 5, SAT_L = 5, EN_H = 4, EN_L = 6;
    localparam int GLITCH_INC = 0;
`else
    localparam int HI_A = 3, LO_A = 5, OV_H = 2, OV_L = 2, SAT_L = 2, EN_H = 4, EN_L = 6;
    localparam int GLITCH_INC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        trigger_in;
    logic        meas_ready;
    logic        clr_overrun;

    logic        meas_valid;
    logic [31:0] meas_hi;
    logic [31:0] meas_lo;
    logic [31:0] trigger_count;
    logic        overrun;

    logic        sat_valid;
    logic [3:0]  sat_hi;
    logic [3:0]  sat_lo;
    logic [31:0] sat_count;
    logic        sat_overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [7:0]  sat_got_q[$];

    always #5 clk = ~clk;

    trigger_capture u_dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .trigger_in    (trigger_in),
        .meas_ready    (meas_ready),
        .meas_valid    (meas_valid),
        .meas_hi       (meas_hi),
        .meas_lo       (meas_lo),
        .trigger_count (trigger_count),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
    );

    trigger_capture #(.W_s(4)) u_sat (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .trigger_in    (trigger_in),
        .meas_ready    (meas_ready),
        .meas_valid    (sat_valid),
        .meas_hi       (sat_hi),
        .meas_lo       (sat_lo),
        .trigger_count (sat_count),
        .overrun       (sat_overrun),
        .clr_overrun   (clr_overrun)
    );

    // Record every beat that will transfer at the next rising edge.
    always @(negedge clk) begin
        if (!rst && meas_valid && meas_ready) got_q.push_back({meas_hi, meas_lo});
        if (!rst && sat_valid && meas_ready) sat_got_q.push_back({sat_hi, sat_lo});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        trigger_in = 1'b1;
        cyc(hi);
        trigger_in = 1'b0;
        cyc(lo);
    endtask

    task automatic idle_fsm();
        enable = 1'b0;
        cyc(2);
        enable = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check(tag, got_q.pop_front(), exp_q.pop_front());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        trigger_in  = 1'b1;
        meas_ready  = 1'b1;
        clr_overrun = 1'b0;
        cyc(3);
        check("rst_valid", 64'(meas_valid), 64'd0);
        check("rst_hi", 64'(meas_hi), 64'd0);
        check("rst_lo", 64'(meas_lo), 64'd0);
        check("rst_count", 64'(trigger_count), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);

        // Line held high through reset release: no rise may be seen.
        rst = 1'b0;
        cyc(20);
        check("high_at_release_valid", 64'(meas_valid), 64'd0);
        check("high_at_release_count", 64'(trigger_count), 64'd0);

        // Four clean periods, consumer always ready.
        trigger_in = 1'b0;
        cyc(10);
        check("fall_in_idle_count", 64'(trigger_count), 64'd0);
        for (int i = 0; i < 4; i++) pulse(HI_A, LO_A);
        cyc(12);
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(HI_A), 32'(LO_A)});
        check_beats("periodic");
        check("periodic_count", 64'(trigger_count), 64'd4);
        check("periodic_overrun", 64'(overrun), 64'd0);
        idle_fsm();

        // Consumer stalled across three periods: first data held, second dropped.
        meas_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(OV_H, OV_L);
        cyc(12);
        check("stall_valid", 64'(meas_valid), 64'd1);
        check("stall_hi", 64'(meas_hi), 64'(OV_H));
        check("stall_lo", 64'(meas_lo), 64'(OV_L));
        check("stall_overrun", 64'(overrun), 64'd1);
        check("stall_count", 64'(trigger_count), 64'd7);
        check("stall_no_transfer", 64'(got_q.size()), 64'd0);
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        check("clr_overrun", 64'(overrun), 64'd0);
        meas_ready = 1'b1;
        cyc(1);
        check("drain_valid", 64'(meas_valid), 64'd0);
        exp_q.push_back({32'(OV_H), 32'(OV_L)});
        check_beats("drain");
        idle_fsm();

        // 20-cycle high: full width on the 32-bit instance, clamped to 15 at W_s=4.
        sat_got_q.delete();
        pulse(20, SAT_L);
        trigger_in = 1'b1;
        cyc(12);
        trigger_in = 1'b0;
        cyc(12);
        exp_q.push_back({32'd20, 32'(SAT_L)});
        check_beats("wide");
        check("sat_beats", 64'(sat_got_q.size()), 64'd1);
        if (sat_got_q.size() > 0) check("sat_value", 64'(sat_got_q[0]), {56'd0, 4'd15, 4'(SAT_L)});
        check("wide_count", 64'(trigger_count), 64'd9);
        idle_fsm();

        // Disable mid-HIGH discards the period; re-enable while high waits for a fresh rise.
        trigger_in = 1'b1;
        cyc(12);
        enable = 1'b0;
        cyc(10);
        enable = 1'b1;
        cyc(3);
        trigger_in = 1'b0;
        cyc(8);
        pulse(EN_H, EN_L);
        trigger_in = 1'b1;
        cyc(12);
        trigger_in = 1'b0;
        cyc(12);
        exp_q.push_back({32'(EN_H), 32'(EN_L)});
        check_beats("enable");
        check("enable_count", 64'(trigger_count), 64'd12);
        idle_fsm();

        // Two-cycle glitch on a low line.
        trigger_in = 1'b1;
        cyc(2);
        trigger_in = 1'b0;
        cyc(15);
        check("glitch_count", 64'(trigger_count), 64'(12 + GLITCH_INC));
        check("glitch_beats", 64'(got_q.size()), 64'd0);
        check("glitch_valid", 64'(meas_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Receive-side counterpart of the trigger generator; sits on the FPGA input from an external peripheral trigger line.
- Synchronises the asynchronous trigger input and measures each pulse's high and low durations in clk cycles.
- Counts accepted triggers.
- Presents each completed period measurement on a valid/ready interface with sticky overrun detection.

Parameters:
- W, 32, width of trigger_count.
- W_s, 32, width of meas_hi / meas_lo (cycle counts, saturating).
- SYNC_STAGES, 2, synchroniser depth (>=2).
- FILT_LEN, 4, glitch filter length in cycles (used only with the optional feature, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; 0 holds FSM in IDLE.
- trigger_in  in  1  asynchronous external trigger line.
- meas_ready  in  1  consumer ready.
- meas_valid  out  1  measurement available.
- meas_hi  out  W_s  high duration of last completed period, in cycles.
- meas_lo  out  W_s  low duration of last completed period, in cycles.
- trigger_count  out  W  number of accepted rising edges, modulo 2^W.
- overrun  out  1  sticky: a measurement was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- **Reset** (synchronous, rst=1 at a clk edge):
  - FSM=IDLE; hi_cnt=lo_cnt=0.
  - meas_valid=0, meas_hi=0, meas_lo=0, trigger_count=0, overrun=0.
  - Synchroniser flops and the edge-detect delay flop reset to 1, so a line already high at reset release produces no rise.
- **Signal path:**
  - trigger_in passes SYNC_STAGES flops to give trig_s, then the optional filter to give trig_f.
  - trig_d = trig_f delayed one cycle.
  - rise = trig_f & ~trig_d; fall = ~trig_f & trig_d.
  - Latency from trigger_in edge to rise/fall: SYNC_STAGES cycles (plus FILT_LEN with the filter).
- **FSM** (evaluated only when enable=1):
  - IDLE: on rise -> HIGH, hi_cnt<=1, trigger_count++.
  - HIGH: on fall -> LOW, lo_cnt<=1; else hi_cnt saturating +1.
  - LOW: on rise -> HIGH, emit (hi_cnt, lo_cnt), hi_cnt<=1, trigger_count++; else lo_cnt saturating +1.
- **Arithmetic:**
  - hi_cnt/lo_cnt saturate at 2^W_s-1 and never wrap.
  - trigger_count wraps 2^W-1 -> 0.
- **Example:** a clean input of 3 cycles high, 5 cycles low gives meas_hi=3, meas_lo=5. The emit occurs on the cycle the second rise is detected; meas_valid=1 the following cycle.
- **Handshake:**
  - Transfer occurs when meas_valid & meas_ready.
  - meas_hi/meas_lo are stable while meas_valid=1 and not transferred.
  - Emit with no pending data, or emit coinciding with a transfer: load new data, meas_valid=1.
  - Transfer with no emit: meas_valid<=0.
  - Emit while meas_valid=1 & meas_ready=0: new data dropped, old data kept, overrun<=1.
- **overrun:** set has priority over clr_overrun in the same cycle.
- **enable=0:**
  - Next cycle FSM=IDLE, hi_cnt=lo_cnt=0; any partial period is discarded.
  - trigger_count, the pending measurement and overrun are retained; the handshake keeps operating.
  - The synchroniser and trig_d keep running, so re-enabling while the line is high waits for the next rise.
- **Simultaneous events:** rise and fall cannot coincide. rst overrides everything.

Optional Feature:
- Macro: TRIG_CAPTURE_GLITCH_FILTER_EN.
- **Defined:**
  - trig_f changes only after trig_s has held the new value for FILT_LEN consecutive cycles; filter state resets to 1.
  - Pulses or gaps shorter than FILT_LEN cycles are ignored.
  - Clean pulse widths are measured unchanged, with FILT_LEN extra latency.
- **Undefined:** trig_f = trig_s; no filter logic is instantiated.

Decomposition:
- Package trigger_capture_pkg:
  - cap_state_t enum (IDLE, HIGH, LOW; 2 bits).
  - Saturating-increment function.
  - Default parameter constants.
- Sub-module trigger_sync_filter: synchroniser, optional filter, delay flop and rise/fall outputs.
- The top level holds the FSM, counters and output register.

Test Plan:
- trigger_in=1 through reset and 20 cycles after -> meas_valid=0, trigger_count=0.
- Periodic 3 high/5 low, meas_ready=1, 4 periods -> 3 valid beats, each meas_hi=3, meas_lo=5; trigger_count=4; overrun=0.
- meas_ready=0 across 3 periods of 2 high/2 low -> first data (2,2) held, overrun=1; pulse clr_overrun -> overrun=0; meas_ready=1 -> one transfer.
- W_s=4, pulse of 20 high then 2 low then rise -> meas_hi=15, meas_lo=2.
- enable=0 mid-HIGH for 10 cycles, then enable=1 -> no emit for that period; the next full 4 high/6 low period is measured as (4,6).
- 2-cycle glitch on a low line, FILT_LEN=4:
  - With macro -> no trigger_count change.
  - Without macro -> trigger_count+1.
